// File: rtl/sq_recon.sv
// Iterative shift-and-add square plus remainder: rad = (root*root + rem) >> FBITS.
// One partial product per cycle over WIDTH cycles, then a final add/scale cycle.
module sq_recon #(
   parameter int WIDTH = 27,
   parameter int FBITS = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] root,
   input  logic [WIDTH-1:0] rem,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] rad,
   output logic             exact,
   output logic             ovf
);

   localparam int AW = 2 * WIDTH + 1;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   // Selects the fraction bits that are truncated away; all-zero when FBITS==0.
   localparam logic [AW-1:0] LOW_MASK = (AW'(1) << FBITS) - AW'(1);

   typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] mcand_reg, mcand_next;
   logic [WIDTH-1:0] mplier_reg, mplier_next;
   logic [AW-1:0]    acc_reg, acc_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] rem_q_reg, rem_q_next;
   logic             busy_reg, busy_next;
   logic             valid_reg, valid_next;
   logic [WIDTH-1:0] rad_reg, rad_next;
   logic             exact_reg, exact_next;
   logic             ovf_reg, ovf_next;

   logic [AW-1:0]    addend;
   logic [AW-1:0]    sum;
   logic             sum_ovf;

   always_comb begin
      state_next  = state_reg;
      mcand_next  = mcand_reg;
      mplier_next = mplier_reg;
      acc_next    = acc_reg;
      cnt_next    = cnt_reg;
      rem_q_next  = rem_q_reg;
      busy_next   = busy_reg;
      valid_next  = valid_reg;
      rad_next    = rad_reg;
      exact_next  = exact_reg;
      ovf_next    = ovf_reg;

      addend  = mplier_reg[0] ? (AW'(mcand_reg) << cnt_reg) : '0;
      sum     = acc_reg + AW'(rem_q_reg);
      sum_ovf = |(sum >> (FBITS + WIDTH));

      case (state_reg)
         IDLE: ;
         MUL: begin
            acc_next    = acc_reg + addend;
            mplier_next = mplier_reg >> 1;
            if (cnt_reg == LAST_CNT) begin
               state_next = ADD;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ADD: begin
            rad_next   = sum[FBITS +: WIDTH];
            ovf_next   = sum_ovf;
            exact_next = ((sum & LOW_MASK) == '0) && !sum_ovf;
            busy_next  = 1'b0;
            valid_next = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // A start in any state discards the current run and loads fresh operands.
      if (start) begin
         mcand_next  = root;
         mplier_next = root;
         rem_q_next  = rem;
         acc_next    = '0;
         cnt_next    = '0;
         busy_next   = 1'b1;
         valid_next  = 1'b0;
         rad_next    = '0;
         exact_next  = 1'b0;
         ovf_next    = 1'b0;
         state_next  = MUL;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         rem_q_reg  <= '0;
         busy_reg   <= 1'b0;
         valid_reg  <= 1'b0;
         rad_reg    <= '0;
         exact_reg  <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         mcand_reg  <= mcand_next;
         mplier_reg <= mplier_next;
         acc_reg    <= acc_next;
         cnt_reg    <= cnt_next;
         rem_q_reg  <= rem_q_next;
         busy_reg   <= busy_next;
         valid_reg  <= valid_next;
         rad_reg    <= rad_next;
         exact_reg  <= exact_next;
         ovf_reg    <= ovf_next;
      end
   end

   assign busy  = busy_reg;
   assign valid = valid_reg;
   assign rad   = rad_reg;
   assign exact = exact_reg;
   assign ovf   = ovf_reg;

endmodule

// File: tb/tb_sq_recon.sv
// Scoreboard bench for sq_recon: driver queues expected results, monitor checks each new valid.
module tb_sq_recon;
   localparam int WIDTH = 27;
   localparam int FBITS = 26;
   localparam int LAT   = 29;   // cycle count from start-drive negedge to first valid negedge

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] root = '0;
   logic [WIDTH-1:0] rem = '0;
   logic             busy, valid, exact, ovf;
   logic [WIDTH-1:0] rad;

   sq_recon #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .root(root), .rem(rem),
      .busy(busy), .valid(valid), .rad(rad), .exact(exact), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] rad;
      logic             exact;
      logic             ovf;
      int               cyc;
      int               tag;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic valid_q = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask

   // Monitor: every rising valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (valid && !valid_q) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got valid with rad=0x%0h, expected no result", rad);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("result tag=%0d rad=0x%0h exact=%0b ovf=%0b cyc=%0d", e.tag, rad, exact, ovf, cyc);
            check($sformatf("rad[%0d]", e.tag), 32'(rad), 32'(e.rad));
            check($sformatf("exact[%0d]", e.tag), 32'(exact), 32'(e.exact));
            check($sformatf("ovf[%0d]", e.tag), 32'(ovf), 32'(e.ovf));
            check($sformatf("latency[%0d]", e.tag), cyc, e.cyc);
            check($sformatf("busy_done[%0d]", e.tag), 32'(busy), 32'd0);
         end
      end
      valid_q = valid;
   end

   // Independent arithmetic reference used for the random operands.
   function automatic exp_t model(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] m, input int tag);
      exp_t e;
      logic [2*WIDTH:0] s;
      s = (55'(r) * 55'(r)) + 55'(m);
      e.rad   = s[FBITS +: WIDTH];
      e.ovf   = |s[2*WIDTH:FBITS+WIDTH];
      e.exact = (s[FBITS-1:0] == '0) && !e.ovf;
      e.cyc   = 0;
      e.tag   = tag;
      return e;
   endfunction

   // Caller is at a negedge; start is held for exactly one rising edge.
   task automatic issue(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] m, input bit push,
                        input logic [WIDTH-1:0] e_rad, input logic e_exact, input logic e_ovf,
                        input int tag);
      exp_t e;
      start = 1'b1;
      root  = r;
      rem   = m;
      if (push) begin
         e.rad = e_rad; e.exact = e_exact; e.ovf = e_ovf; e.cyc = cyc + LAT; e.tag = tag;
         sb.push_back(e);
      end
      $display("start tag=%0d root=0x%0h rem=0x%0h expect=%0b", tag, r, m, push);
      @(negedge clk);
      start = 1'b0;
      root  = WIDTH'($urandom);
      rem   = WIDTH'($urandom);
      check($sformatf("busy_run[%0d]", tag), 32'(busy), 32'd1);
      check($sformatf("valid_cleared[%0d]", tag), 32'(valid), 32'd0);
   endtask

   task automatic wait_done(input int tag);
      int n;
      n = 0;
      while (!valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout[%0d]: got no valid in %0d cycles, expected valid", tag, n);
      end
   endtask

   task automatic run(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] m,
                      input logic [WIDTH-1:0] e_rad, input logic e_exact, input logic e_ovf,
                      input int tag);
      issue(r, m, 1'b1, e_rad, e_exact, e_ovf, tag);
      wait_done(tag);
   endtask

   initial begin
      exp_t e;
      logic [WIDTH-1:0] r, m;

      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_valid", 32'(valid), 32'd0);
      check("reset_rad", 32'(rad), 32'd0);
      check("reset_exact", 32'(exact), 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run(27'h4000000, 27'h0,       27'h4000000, 1'b1, 1'b0, 1);
      repeat (3) @(negedge clk);
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_rad", 32'(rad), 32'h4000000);

      @(negedge clk);
      run(27'd11585,   27'd5503,    27'd2,       1'b1, 1'b0, 2);
      @(negedge clk);
      run(27'h7FFFFFF, 27'h0,       27'h7FFFFFC, 1'b0, 1'b1, 3);
      @(negedge clk);
      run(27'h0,       27'h4000000, 27'h1,       1'b1, 1'b0, 4);
      @(negedge clk);
      run(27'h0,       27'h1,       27'h0,       1'b0, 1'b0, 5);
      @(negedge clk);
      run(27'h0,       27'h0,       27'h0,       1'b1, 1'b0, 6);
      @(negedge clk);
      run(27'h7FFFFFF, 27'h7FFFFFF, 27'h7FFFFFE, 1'b0, 1'b1, 7);
      @(negedge clk);
      run(27'h6000000, 27'h0,       27'h1000000, 1'b0, 1'b1, 8);

      // Restart 5 cycles into a run: only the second run may report.
      @(negedge clk);
      issue(27'h5555555, 27'h123, 1'b0, '0, 1'b0, 1'b0, 9);
      repeat (4) @(negedge clk);
      run(27'h4000000, 27'h0, 27'h4000000, 1'b1, 1'b0, 10);

      // Reset while holding a result clears it.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_done_valid", 32'(valid), 32'd0);
      check("rst_done_rad", 32'(rad), 32'd0);
      check("rst_done_exact", 32'(exact), 32'd0);
      rst_n = 1'b1;

      // Reset mid-run aborts; no result may appear afterwards.
      @(negedge clk);
      issue(27'h4000000, 27'h0, 1'b0, '0, 1'b0, 1'b0, 11);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_run_busy", 32'(busy), 32'd0);
      check("rst_run_valid", 32'(valid), 32'd0);
      check("rst_run_rad", 32'(rad), 32'd0);
      check("rst_run_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      // Back-to-back: each new start lands on the cycle the previous result appears.
      r = WIDTH'($urandom);
      m = WIDTH'($urandom);
      e = model(r, m, 20);
      issue(r, m, 1'b1, e.rad, e.exact, e.ovf, 20);
      for (int i = 1; i <= 6; i++) begin
         wait_done(19 + i);
         r = WIDTH'($urandom);
         m = WIDTH'($urandom);
         e = model(r, m, 20 + i);
         issue(r, m, 1'b1, e.rad, e.exact, e.ovf, 20 + i);
      end
      wait_done(26);
      @(negedge clk);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
